// File: rtl/mio_rr_arbiter.sv
// mio_rr_arbiter: round-robin arbiter sharing one MIO bus among NUM_MASTERS requesters; bus timeout enabled by MIO_ARB_TIMEOUT_EN
module mio_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_mio,
  input  logic [NUM_MASTERS-1:0]        m_w,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_err,
  output logic                          CPU_MIO,
  output logic                          mem_w,
  output logic [ADDR_W-1:0]             Addr_out,
  output logic [DATA_W-1:0]             Data_out,
  input  logic [DATA_W-1:0]             Data_in,
  input  logic                          MIO_ready,
  output logic [2:0]                    grant_id,
  output logic                          busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [2:0] last, win;
  logic [NUM_MASTERS-1:0] rot;
  logic hit, tmo;
  // first requester found scanning from last+1 around the ring
  always_comb begin
    win = last;
    hit = 1'b0;
    rot = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      rot = m_mio >> ((int'(last) + i) % NUM_MASTERS);
      if (rot[0]) begin
        win = 3'((int'(last) + i) % NUM_MASTERS);
        hit = 1'b1;
      end
    end
  end
  logic w_sel;
  logic [NUM_MASTERS-1:0] w_rot;
  assign w_rot = m_w >> win;
  assign w_sel = w_rot[0];
`ifdef MIO_ARB_TIMEOUT_EN
  localparam int CW = TIMEOUT > 255 ? 16 : 8;
  logic [CW-1:0] cnt;
  assign tmo = (cnt + 1'b1) == CW'(TIMEOUT);
  // BUSY-cycle counter, zero on every entry into BUSY
  always_ff @(posedge clk) cnt <= (!reset || state != BUSY) ? '0 : cnt + 1'b1;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign tmo = 1'b0;
`endif
  // arbitration FSM with registered bus and master-side outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      last <= 3'(NUM_MASTERS - 1);
      grant_id <= '0;
      CPU_MIO <= 1'b0;
      mem_w <= 1'b0;
      Addr_out <= '0;
      Data_out <= '0;
      m_rdata <= '0;
      m_ready <= '0;
      m_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      m_ready <= '0;
      case (state)
        IDLE: if (hit) begin
          state <= BUSY;
          busy <= 1'b1;
          CPU_MIO <= 1'b1;
          mem_w <= w_sel;
          Addr_out <= ADDR_W'(m_addr >> (int'(win) * ADDR_W));
          Data_out <= DATA_W'(m_wdata >> (int'(win) * DATA_W));
          grant_id <= win;
          last <= win;
        end
        BUSY: if (MIO_ready || tmo) begin
          state <= DONE;
          CPU_MIO <= 1'b0;
          mem_w <= 1'b0;
          m_ready <= NUM_MASTERS'(1) << grant_id;
          m_err <= !MIO_ready;
          m_rdata <= MIO_ready ? Data_in : '0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/mio_rr_arbiter.md
# mio_rr_arbiter

Parametrised round-robin arbiter sharing the single MIO memory/peripheral bus among `NUM_MASTERS` multi-cycle CPU cores or DMA-style requesters. It sits between the masters' `CPU_MIO`/`mem_w`/`Addr_out`/`Data_out` request side and the bus's `Data_in`/`MIO_ready` completion side. It serialises one transaction at a time and returns a one-cycle ready pulse with read data to the granted master. It generalises the single-CPU, single-bus handshake to N channels with fair arbitration and an optional bus timeout.

## Interface
- `NUM_MASTERS`, default 2: number of requesting channels, 2..8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 255: cycles to wait for `MIO_ready` before abort; used only with `MIO_ARB_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: **synchronous, active-low** reset (asserted when 0).
- `m_mio` in NUM_MASTERS: per-master request (master's `CPU_MIO`).
- `m_w` in NUM_MASTERS: per-master write flag (1 = write).
- `m_addr` in NUM_MASTERS*ADDR_W: flattened addresses; master i at `[i*ADDR_W +: ADDR_W]`.
- `m_wdata` in NUM_MASTERS*DATA_W: flattened write data, same packing.
- `m_ready` out NUM_MASTERS: one-hot, one-cycle completion pulse to the granted master.
- `m_rdata` out DATA_W: read data, shared by all masters, valid while `m_ready` is nonzero.
- `m_err` out 1: timeout abort flag, qualified by `m_ready`.
- `CPU_MIO` out 1: bus request, high for the whole bus phase.
- `mem_w` out 1: bus write strobe.
- `Addr_out` out ADDR_W: bus address.
- `Data_out` out DATA_W: bus write data.
- `Data_in` in DATA_W: bus read data.
- `MIO_ready` in 1: bus completion, sampled only in BUSY.
- `grant_id` out 3: index of the current or last granted master (test).
- `busy` out 1: high whenever state ≠ IDLE (test).

## Operation
- States: IDLE → BUSY → DONE → IDLE.
- **IDLE.** If any `m_mio` is high, pick the winner by round-robin starting at `(last+1) mod NUM_MASTERS`.
  - Register the winner's addr, wdata and w into the bus outputs, set `grant_id`, update `last`, and go to BUSY.
  - With no request, remain in IDLE.
- **BUSY.** `CPU_MIO`=1 and `mem_w`=`m_w` of the granted master; `Addr_out`/`Data_out` are held constant.
  - On an edge with `MIO_ready`=1: capture `Data_in` into `m_rdata` (also for writes), clear `m_err`, go to DONE.
- **DONE.** `m_ready[grant_id]`=1 for exactly this cycle; `CPU_MIO`=`mem_w`=0. Requests are ignored. Next state is IDLE.
- Masters hold `m_mio`, `m_w`, `m_addr` and `m_wdata` stable from assertion until they sample their `m_ready` pulse.
  - At that edge a master either drops `m_mio` or presents a new request.
  - A request still high in IDLE is treated as a new transaction.
- `m_mio` changes on non-granted channels never disturb an ongoing transaction.
- Reset values:
  - State IDLE; `last` = NUM_MASTERS-1, so master 0 wins the first tie.
  - `CPU_MIO`, `mem_w`, `m_ready` and `m_err` = 0.
  - `Addr_out`, `Data_out`, `m_rdata` and `grant_id` = 0; `busy` = 0.
- Between transactions, `Addr_out`, `Data_out`, `m_rdata` and `grant_id` hold their last values.
- Reset asserted mid-transaction: everything returns to reset values at that edge. No `m_ready` pulse is issued for the dropped transaction.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Request seen at edge 0 → bus phase from cycle 1.
  - `MIO_ready` high in cycle k (k ≥ 1) → DONE and `m_ready` in cycle k+1.
  - Minimum request-to-ready latency: 2 cycles. Back-to-back throughput: one transaction per 3 cycles.
- `MIO_ready` outside BUSY is ignored.
- Under continuous requests from all masters, each master is granted once per NUM_MASTERS transactions.

## Configuration
- `MIO_ARB_TIMEOUT_EN` defined:
  - An 8..16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches `TIMEOUT` with no `MIO_ready`, the arbiter goes to DONE with `m_err`=1 and `m_rdata`=0.
  - If `MIO_ready` arrives in the same cycle the counter reaches `TIMEOUT`, the transaction completes normally.
- Not defined: no counter; BUSY waits indefinitely; `m_err` is tied to 0.

## Test plan
- Single read: master 0 reads 0x0000_0040, `MIO_ready` held high, `Data_in`=0xA5A5_0001 → `CPU_MIO` high in cycle 1, `m_ready`=2'b01 and `m_rdata`=0xA5A5_0001 in cycle 2.
- Write with wait states: master 1 writes 0x1234_5678 to 0x0000_0080, `MIO_ready` low 3 cycles → `mem_w`=1 and `Addr_out`/`Data_out` stable for 4 BUSY cycles; one `m_ready`=2'b10 pulse.
- Fairness: both masters request continuously for 6 transactions → grant order 0,1,0,1,0,1.
- Mid-transaction reset: reset=0 during BUSY → next cycle all outputs 0, no `m_ready`; master 0 wins the first grant after release.
- Timeout (`MIO_ARB_TIMEOUT_EN`, TIMEOUT=10): `MIO_ready` never asserted → `m_ready` with `m_err`=1 and `m_rdata`=0 after 10 BUSY cycles.
- Stray ready: `MIO_ready` pulsed while in IDLE with no requests → state stays IDLE, `m_ready`=0.
